jb_target_unit: RTL and testbench
=================================

// Module: jb_target_unit
// PURPOSE
//  Parametrised jump/branch target unit for the EX stage. Computes XLEN-wide targets for JAL/JALR/BRANCH,
//  clears bit0 for JALR, flags misaligned targets and link address (pc+4). Result held in a one-entry
//  valid/ready output register. A return-address stack (RAS) is updated per RISC-V link hints, offering
//  a prediction to the fetch stage.
// PARAMETERS
//  XLEN       64  datapath width (32 or 64)
//  RAS_DEPTH  8   RAS entries (power of 2, >=2)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     request valid
//  in_ready   out  1     unit can accept request
//  opcode     in   7     1101111 JAL, 1100111 JALR, 1100011 BRANCH; others: plain add, no RAS action
//  operand1   in   XLEN  base (pc or rs1 value)
//  operand2   in   XLEN  offset (sign-extended imm)
//  pc         in   XLEN  pc of instruction
//  rd         in   5     destination reg index
//  rs1        in   5     source reg index
//  flush      in   1     pipeline kill
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  jb_out     out  XLEN  target address
//  link_addr  out  XLEN  pc+4
//  misalign   out  1     target not instruction-aligned
//  ras_pred   out  XLEN  RAS top entry
//  ras_valid  out  1     RAS non-empty
// BEHAVIOUR
//  Reset: out_valid=0, jb_out=0, link_addr=0, misalign=0, RAS count=0, top ptr=0, entries=0; ras_valid=0.
//  Handshake: in_ready = !out_valid | out_ready (comb). fire = in_valid & in_ready & !flush.
//  Latency 1: on fire, next edge loads output regs, out_valid=1. Output held stable while out_valid & !out_ready.
//  out_valid clears at the edge where out_ready=1 and no new fire.
//  flush: at next edge out_valid=0 and request dropped (no RAS update); flush beats simultaneous fire.
//  Arithmetic: sum = operand1+operand2 mod 2^XLEN (carry dropped); JALR: jb_out = sum & ~1; else jb_out = sum.
//  link_addr = pc+4 mod 2^XLEN.
//  misalign = jb_out[1] (jb_out[0] is always 0 for JALR; for JAL/BRANCH imm is even).
//  link(r) = (r==1)|(r==5).
//  RAS on fire only:
//   JAL, link(rd): push link_addr.
//   JALR, !link(rd), link(rs1): pop.
//   JALR, link(rd), !link(rs1): push.
//   JALR, link(rd), link(rs1), rd!=rs1: pop then push (replace top; count unchanged, 1 if was 0).
//   JALR, link(rd), link(rs1), rd==rs1: push.
//   BRANCH/other: none.
//  RAS is circular: push when full overwrites oldest, count saturates at RAS_DEPTH.
//  Pop when empty: no-op.
//  ras_pred/ras_valid are comb from registered state (reflect updates the edge after fire).
//  rst_n low mid-operation: immediate clear of all state regardless of clock; pending result lost.
// CONFIGURATION
//  RVC_EN defined: misalign = 0 always (2-byte alignment; jb_out[0] never checked since JAL/BRANCH offsets
//   are even and JALR clears bit0).
//  RVC_EN undefined: misalign = jb_out[1] as above.
//  RAS behaviour identical in both.
// TESTING
//  1 JALR op1=0x1003 op2=0x4, XLEN=64 -> jb_out=0x1006, misalign=1 (0 with RVC_EN), out_valid 1 cycle later.
//  2 Backpressure: fire, out_ready=0 for 3 cycles -> out held, in_ready=0; out_ready=1 + new in_valid
//    -> back-to-back accept, no bubble.
//  3 Wrap: op1=0xFFFF_FFFF_FFFF_FFFC, op2=0x8 -> jb_out=0x4; pc=0xFFFF_FFFF_FFFF_FFFC -> link_addr=0x0.
//  4 RAS: JAL rd=x1 pc=0x100, then JALR rd=x0 rs1=x1 -> ras_pred=0x104 after first, ras_valid=0 after pop.
//  5 Overflow: RAS_DEPTH+1 pushes pc=0x0,0x10,... -> count=RAS_DEPTH, oldest lost; pop on empty -> no change.
//  6 flush with in_valid high -> out_valid=0, RAS unchanged; async rst_n pulse mid-hold -> all outputs 0 at once.

Source files
------------

// File: rtl/jb_target_unit.sv
// Jump/branch target unit for EX: target/link/misalign computation behind a one-entry
// valid/ready output register, plus a circular return-address stack. Optional macro: RVC_EN.
module jb_target_unit #(
    parameter int XLEN      = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] jb_out,
    output logic [XLEN-1:0] link_addr,
    output logic            misalign,
    output logic [XLEN-1:0] ras_pred,
    output logic            ras_valid
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RAS_NONE = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_REPL = 2'd3
    } ras_op_e;

    // x1 and x5 are the architectural link registers
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    logic            out_valid_r;
    logic [XLEN-1:0] jb_out_r;
    logic [XLEN-1:0] link_addr_r;
    logic            misalign_r;

    logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] top_r;
    logic [CNT_W-1:0] cnt_r;

    logic            fire_s;
    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] link_s;
    logic            misalign_s;
    ras_op_e         ras_op_s;

    logic             ras_wr_en_s;
    logic [PTR_W-1:0] ras_wr_idx_s;
    logic [PTR_W-1:0] top_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    assign in_ready  = !out_valid_r | out_ready;
    assign fire_s    = in_valid & in_ready & !flush;

    assign out_valid = out_valid_r;
    assign jb_out    = jb_out_r;
    assign link_addr = link_addr_r;
    assign misalign  = misalign_r;
    assign ras_pred  = ras_mem_r[top_r];
    assign ras_valid = (cnt_r != {CNT_W{1'b0}});

    // Target, link address and alignment flag for the incoming request
    always_comb begin
        sum_s    = operand1 + operand2;
        link_s   = pc + XLEN'(4);
        target_s = sum_s;
        if (opcode == OP_JALR) begin
            target_s = {sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_s = sum_s;
        end
`ifdef RVC_EN
        misalign_s = 1'b0;
`else
        misalign_s = target_s[1];
`endif
    end

    // Decode the RAS action from the link hints
    always_comb begin
        ras_op_s = RAS_NONE;
        case (opcode)
            OP_JAL: begin
                if (is_link(rd)) begin
                    ras_op_s = RAS_PUSH;
                end else begin
                    ras_op_s = RAS_NONE;
                end
            end
            OP_JALR: begin
                case ({is_link(rd), is_link(rs1)})
                    2'b01:   ras_op_s = RAS_POP;
                    2'b10:   ras_op_s = RAS_PUSH;
                    2'b11:   ras_op_s = (rd == rs1) ? RAS_PUSH : RAS_REPL;
                    default: ras_op_s = RAS_NONE;
                endcase
            end
            OP_BRANCH: ras_op_s = RAS_NONE;
            default:   ras_op_s = RAS_NONE;
        endcase
    end

    // Next RAS pointer/count and write port; a replace on an empty stack acts as a push
    always_comb begin
        ras_wr_en_s  = 1'b0;
        ras_wr_idx_s = top_r + PTR_W'(1);
        top_nxt_s    = top_r;
        cnt_nxt_s    = cnt_r;
        if (fire_s) begin
            case (ras_op_s)
                RAS_PUSH: begin
                    ras_wr_en_s  = 1'b1;
                    ras_wr_idx_s = top_r + PTR_W'(1);
                    top_nxt_s    = top_r + PTR_W'(1);
                    if (cnt_r != CNT_W'(RAS_DEPTH)) begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                RAS_POP: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        top_nxt_s = top_r - PTR_W'(1);
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end else begin
                        top_nxt_s = top_r;
                        cnt_nxt_s = cnt_r;
                    end
                end
                RAS_REPL: begin
                    ras_wr_en_s = 1'b1;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        ras_wr_idx_s = top_r + PTR_W'(1);
                        top_nxt_s    = top_r + PTR_W'(1);
                        cnt_nxt_s    = CNT_W'(1);
                    end else begin
                        ras_wr_idx_s = top_r;
                        top_nxt_s    = top_r;
                        cnt_nxt_s    = cnt_r;
                    end
                end
                default: begin
                    ras_wr_en_s = 1'b0;
                end
            endcase
        end else begin
            ras_wr_en_s = 1'b0;
        end
    end

    // RAS storage, top pointer and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {XLEN{1'b0}};
            end
            top_r <= {PTR_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (ras_wr_en_s) begin
                ras_mem_r[ras_wr_idx_s] <= link_s;
            end
            top_r <= top_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Output register: flush kills, fire loads, consumer drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            jb_out_r    <= {XLEN{1'b0}};
            link_addr_r <= {XLEN{1'b0}};
            misalign_r  <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (fire_s) begin
            out_valid_r <= 1'b1;
            jb_out_r    <= target_s;
            link_addr_r <= link_s;
            misalign_r  <= misalign_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jb_target_unit.sv
// Directed bench for jb_target_unit: vector table for the arithmetic plus hand sequences
// for backpressure, RAS push/pop/replace/overflow, flush and asynchronous reset.
module tb_jb_target_unit;

    localparam int XLEN      = 64;
    localparam int RAS_DEPTH = 8;
`ifdef RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] ALU    = 7'b0110011;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] jb_out;
    logic [XLEN-1:0] link_addr;
    logic            misalign;
    logic [XLEN-1:0] ras_pred;
    logic            ras_valid;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [6:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] pcv;
        logic [4:0]  rdv;
        logic [4:0]  rs1v;
        logic [63:0] exp_jb;
        logic [63:0] exp_link;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [7];

    jb_target_unit #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2), .pc(pc),
        .rd(rd), .rs1(rs1), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .jb_out(jb_out), .link_addr(link_addr),
        .misalign(misalign), .ras_pred(ras_pred), .ras_valid(ras_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] pcv, input logic [4:0] rdv, input logic [4:0] rs1v);
        in_valid = 1'b1;
        opcode   = op;
        operand1 = a;
        operand2 = b;
        pc       = pcv;
        rd       = rdv;
        rs1      = rs1v;
    endtask

    // Single accepted request with the consumer ready, then idle
    task automatic issue(input logic [6:0] op, input logic [63:0] pcv,
                         input logic [4:0] rdv, input logic [4:0] rs1v);
        drive(op, pcv, 64'h0, pcv, rdv, rs1v);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        opcode = 7'd0;
        operand1 = 64'd0;
        operand2 = 64'd0;
        pc = 64'd0;
        rd = 5'd0;
        rs1 = 5'd0;
        flush = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{JALR,   64'h1003, 64'h4, 64'h2000, 5'd0, 5'd2, 64'h1006, 64'h2004, 1'b1};
        vecs[1] = '{BRANCH, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0,
                    64'h4, 64'h0, 1'b0};
        vecs[2] = '{JAL,    64'h1000, 64'h22, 64'h1000, 5'd0, 5'd0, 64'h1022, 64'h1004, 1'b1};
        vecs[3] = '{ALU,    64'h3, 64'h0, 64'h0, 5'd1, 5'd5, 64'h3, 64'h4, 1'b1};
        vecs[4] = '{JALR,   64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd0, 5'd0, 64'h6, 64'h14, 1'b1};
        vecs[5] = '{BRANCH, 64'h8000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h8000, 5'd1, 5'd1,
                    64'h7FF0, 64'h8004, 1'b0};
        vecs[6] = '{JALR,   64'h100, 64'h1, 64'h200, 5'd2, 5'd3, 64'h100, 64'h204, 1'b0};

        step();
        step();
        rst_n = 1'b1;
        step();

        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_jb_out", jb_out, 64'd0);
        check("rst_link", link_addr, 64'd0);
        check("rst_misalign", {63'd0, misalign}, 64'd0);
        check("rst_ras_valid", {63'd0, ras_valid}, 64'd0);
        check("rst_ras_pred", ras_pred, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Arithmetic table; none of these entries changes the RAS
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pcv, vecs[i].rdv, vecs[i].rs1v);
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_jb", i), jb_out, vecs[i].exp_jb);
            check($sformatf("vec%0d_link", i), link_addr, vecs[i].exp_link);
            check($sformatf("vec%0d_mis", i), {63'd0, misalign}, RVC ? 64'd0 : {63'd0, vecs[i].exp_mis});
        end
        step();
        check("tbl_drained", {63'd0, out_valid}, 64'd0);
        check("tbl_ras_untouched", {63'd0, ras_valid}, 64'd0);

        // Backpressure: hold for three cycles, then back-to-back accept
        out_ready = 1'b0;
        drive(BRANCH, 64'h40, 64'h10, 64'h40, 5'd0, 5'd0);
        step();
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_jb", jb_out, 64'h50);
        drive(BRANCH, 64'h200, 64'h8, 64'h300, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_hold_jb%0d", c), jb_out, 64'h50);
            check($sformatf("bp_hold_link%0d", c), link_addr, 64'h44);
            check($sformatf("bp_hold_valid%0d", c), {63'd0, out_valid}, 64'd1);
            check($sformatf("bp_in_ready%0d", c), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_b2b_valid", {63'd0, out_valid}, 64'd1);
        check("bp_b2b_jb", jb_out, 64'h208);
        check("bp_b2b_link", link_addr, 64'h304);
        step();
        check("bp_drain", {63'd0, out_valid}, 64'd0);

        // RAS basic push then pop
        issue(JAL, 64'h100, 5'd1, 5'd0);
        check("ras_push_valid", {63'd0, ras_valid}, 64'd1);
        check("ras_push_pred", ras_pred, 64'h104);
        issue(JALR, 64'h104, 5'd0, 5'd1);
        check("ras_pop_valid", {63'd0, ras_valid}, 64'd0);

        // Overflow: RAS_DEPTH+1 pushes, then drain
        for (int k = 0; k <= RAS_DEPTH; k++) begin
            issue(JAL, 64'(k * 16), 5'd5, 5'd0);
        end
        check("ovf_pred", ras_pred, 64'h84);
        for (int k = 1; k < RAS_DEPTH; k++) begin
            issue(JALR, 64'h0, 5'd0, 5'd5);
            check($sformatf("ovf_pop%0d_pred", k), ras_pred, 64'h84 - 64'(k * 16));
            check($sformatf("ovf_pop%0d_valid", k), {63'd0, ras_valid}, 64'd1);
        end
        issue(JALR, 64'h0, 5'd0, 5'd5);
        check("ovf_oldest_lost", {63'd0, ras_valid}, 64'd0);
        issue(JALR, 64'h0, 5'd0, 5'd1);
        check("empty_pop_valid", {63'd0, ras_valid}, 64'd0);
        issue(JAL, 64'h900, 5'd1, 5'd0);
        check("after_empty_push_pred", ras_pred, 64'h904);
        issue(JALR, 64'h0, 5'd0, 5'd1);
        check("after_empty_pop_valid", {63'd0, ras_valid}, 64'd0);

        // Replace (rd!=rs1 links) keeps count; rd==rs1 link pushes
        issue(JAL, 64'h300, 5'd1, 5'd0);
        issue(JALR, 64'h400, 5'd1, 5'd5);
        check("repl_pred", ras_pred, 64'h404);
        issue(JALR, 64'h0, 5'd0, 5'd1);
        check("repl_count_kept", {63'd0, ras_valid}, 64'd0);
        issue(JALR, 64'h500, 5'd5, 5'd1);
        check("repl_empty_pred", ras_pred, 64'h504);
        check("repl_empty_valid", {63'd0, ras_valid}, 64'd1);
        issue(JALR, 64'h600, 5'd5, 5'd5);
        check("same_link_push_pred", ras_pred, 64'h604);
        issue(JALR, 64'h0, 5'd0, 5'd5);
        check("same_link_pop_pred", ras_pred, 64'h504);
        check("same_link_pop_valid", {63'd0, ras_valid}, 64'd1);
        issue(JALR, 64'h0, 5'd0, 5'd5);
        check("same_link_empty", {63'd0, ras_valid}, 64'd0);
        step();

        // Flush beats a simultaneous fire
        drive(JAL, 64'h700, 64'h0, 64'h700, 5'd1, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_ras", {63'd0, ras_valid}, 64'd0);

        // Flush kills a held result
        out_ready = 1'b0;
        issue(BRANCH, 64'h800, 5'd0, 5'd0);
        check("flush_hold_pre", {63'd0, out_valid}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_hold_kill", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset during a held result
        issue(JAL, 64'hA00, 5'd1, 5'd0);
        check("arst_pre_valid", {63'd0, out_valid}, 64'd1);
        check("arst_pre_ras", {63'd0, ras_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_jb", jb_out, 64'd0);
        check("arst_link", link_addr, 64'd0);
        check("arst_mis", {63'd0, misalign}, 64'd0);
        check("arst_ras_valid", {63'd0, ras_valid}, 64'd0);
        check("arst_ras_pred", ras_pred, 64'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("arst_after_valid", {63'd0, out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
